// File: rtl/osf_pkg.sv
// osf_pkg
//   Shared definitions for the per-channel oversampling averager.
//   - osf_state_e      : FSM state encoding (IDLE, DELAY, SUM)
//   - OSM_MAX_DEFAULT  : largest honoured log2 oversample ratio
//   - acc_width()      : accumulator width needed to sum 2^osm_max samples
package osf_pkg;

  // Default ceiling on the log2 oversample ratio; larger requests are clamped.
  localparam int OSM_MAX_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    SUM   = 2'd2
  } osf_state_e;

  // Summing 2^osm_max full-scale samples needs osm_max extra bits of headroom.
  function automatic int acc_width(input int w_adc_data, input int osm_max);
    return w_adc_data + osm_max;
  endfunction

endpackage

// File: rtl/oversample_filter.sv
// oversample_filter
//   Per-ADC-channel oversampling averager. After activation or a parameter
//   commit it discards cd_r valid samples, then sums 2^osm_r valid samples and
//   emits their arithmetic mean (floor) as a one-cycle-valid word.
//
// Ports:
//   clk_in            system clock
//   reset_n_in        synchronous active-low reset
//   adc_data_valid_in one-cycle strobe, adc_data_in holds a new sample
//   adc_data_in       signed ADC sample
//   activate_in       channel enable level
//   cycle_delay_in    staged discard count
//   osm_in            staged log2 oversample ratio
//   update_en_in      this channel accepts the next module update
//   module_update_in  one-cycle global parameter-commit strobe
//   data_valid_out    one-cycle strobe, data_out updated
//   data_out          signed averaged sample, held between strobes
module oversample_filter
  import osf_pkg::*;
#(
  parameter int W_ADC_DATA = 18,
  parameter int W_OSF_CD   = 16,
  parameter int W_OSF_OSM  = 6,
  parameter int OSM_MAX    = OSM_MAX_DEFAULT
) (
  input  logic                         clk_in,
  input  logic                         reset_n_in,
  input  logic                         adc_data_valid_in,
  input  logic signed [W_ADC_DATA-1:0] adc_data_in,
  input  logic                         activate_in,
  input  logic        [W_OSF_CD-1:0]   cycle_delay_in,
  input  logic        [W_OSF_OSM-1:0]  osm_in,
  input  logic                         update_en_in,
  input  logic                         module_update_in,
  output logic                         data_valid_out,
  output logic signed [W_ADC_DATA-1:0] data_out
);

  localparam int W_ACC = acc_width(W_ADC_DATA, OSM_MAX);
  // Sample counter must be able to hold the value 2^OSM_MAX itself.
  localparam int W_CNT = OSM_MAX + 1;
  localparam logic [W_CNT-1:0]     CNT_ONE   = W_CNT'(1);
  localparam logic [W_OSF_CD-1:0]  DLY_ONE   = W_OSF_CD'(1);
  localparam logic [W_OSF_OSM-1:0] OSM_LIMIT = W_OSF_OSM'(OSM_MAX);

  osf_state_e                  state;
  logic signed [W_ACC-1:0]     acc;
  logic        [W_CNT-1:0]     sample_cnt;
  logic        [W_OSF_CD-1:0]  delay_cnt;
  logic        [W_OSF_CD-1:0]  cd_r;
  logic        [W_OSF_OSM-1:0] osm_r;

  logic signed [W_ACC-1:0]      sample_ext;
  logic signed [W_ACC-1:0]      acc_sum;
  logic signed [W_ADC_DATA-1:0] avg;
  logic        [W_CNT-1:0]      sample_cnt_next;
  logic        [W_CNT-1:0]      ratio;
  logic        [W_OSF_CD-1:0]   delay_cnt_next;
  logic        [W_OSF_OSM-1:0]  osm_clamped;
  logic                         commit;

  // Datapath helpers: sign-extend the incoming sample into the accumulator
  // width, form the running sum including the current sample, and derive the
  // floor-average by arithmetic right shift. The ratio 2^osm_r is the sample
  // count at which a block is complete. osm_r never exceeds OSM_MAX, so the
  // shift never leaves the counter width.
  always_comb begin
    sample_ext      = {{OSM_MAX{adc_data_in[W_ADC_DATA-1]}}, adc_data_in};
    acc_sum         = acc + sample_ext;
    avg             = W_ADC_DATA'(acc_sum >>> osm_r);
    sample_cnt_next = sample_cnt + CNT_ONE;
    delay_cnt_next  = delay_cnt + DLY_ONE;
    ratio           = CNT_ONE << osm_r;
    osm_clamped     = (osm_in > OSM_LIMIT) ? OSM_LIMIT : osm_in;
    commit          = module_update_in & update_en_in;
  end

  // Main control and datapath. Priority inside a cycle is reset, then
  // parameter commit, then deactivation, then normal sample processing.
  // data_valid_out defaults low every cycle and is raised only on the edge
  // that completes a block in SUM.
  always_ff @(posedge clk_in) begin
    data_valid_out <= 1'b0;
    if (!reset_n_in) begin
      state      <= IDLE;
      acc        <= '0;
      sample_cnt <= '0;
      delay_cnt  <= '0;
      cd_r       <= '0;
      osm_r      <= '0;
      data_out   <= '0;
    end else if (commit) begin
      // New parameters restart averaging from scratch; a sample arriving in
      // this cycle is intentionally dropped.
      cd_r       <= cycle_delay_in;
      osm_r      <= osm_clamped;
      acc        <= '0;
      sample_cnt <= '0;
      delay_cnt  <= '0;
      if (!activate_in) begin
        state <= IDLE;
      end else if (cycle_delay_in != '0) begin
        state <= DELAY;
      end else begin
        state <= SUM;
      end
    end else if (!activate_in) begin
      // A partial block is abandoned without output; data_out keeps its value.
      state      <= IDLE;
      acc        <= '0;
      sample_cnt <= '0;
      delay_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          delay_cnt  <= '0;
          sample_cnt <= '0;
          acc        <= '0;
          state      <= (cd_r != '0) ? DELAY : SUM;
        end
        DELAY: begin
          if (adc_data_valid_in) begin
            if (delay_cnt_next == cd_r) begin
              delay_cnt <= '0;
              state     <= SUM;
            end else begin
              delay_cnt <= delay_cnt_next;
            end
          end
        end
        SUM: begin
          if (adc_data_valid_in) begin
            if (sample_cnt_next == ratio) begin
              data_out       <= avg;
              data_valid_out <= 1'b1;
              acc            <= '0;
              sample_cnt     <= '0;
            end else begin
              acc        <= acc_sum;
              sample_cnt <= sample_cnt_next;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oversample_filter.sv
// tb_oversample_filter
//   Self-checking bench for oversample_filter. Stimulus is driven on the
//   falling edge; every expected average is queued with the cycle it is due
//   and a falling-edge monitor pops and compares each data_valid_out strobe.
module tb_oversample_filter;

  localparam int W_ADC_DATA = 18;
  localparam int W_OSF_CD   = 16;
  localparam int W_OSF_OSM  = 6;

  logic                         clk_in;
  logic                         reset_n_in;
  logic                         adc_data_valid_in;
  logic signed [W_ADC_DATA-1:0] adc_data_in;
  logic                         activate_in;
  logic        [W_OSF_CD-1:0]   cycle_delay_in;
  logic        [W_OSF_OSM-1:0]  osm_in;
  logic                         update_en_in;
  logic                         module_update_in;
  logic                         data_valid_out;
  logic signed [W_ADC_DATA-1:0] data_out;

  typedef struct {
    int value;
    int due;
  } exp_t;

  typedef struct {
    logic signed [W_ADC_DATA-1:0] sample;
    logic signed [W_ADC_DATA-1:0] expected;
  } vec_t;

  exp_t sb_q[$];
  exp_t head;
  vec_t vecs[6];
  int   checks;
  int   errors;
  int   cyc;
  bit   mon_en;

  oversample_filter #(
    .W_ADC_DATA(W_ADC_DATA),
    .W_OSF_CD  (W_OSF_CD),
    .W_OSF_OSM (W_OSF_OSM),
    .OSM_MAX   (10)
  ) dut (
    .clk_in           (clk_in),
    .reset_n_in       (reset_n_in),
    .adc_data_valid_in(adc_data_valid_in),
    .adc_data_in      (adc_data_in),
    .activate_in      (activate_in),
    .cycle_delay_in   (cycle_delay_in),
    .osm_in           (osm_in),
    .update_en_in     (update_en_in),
    .module_update_in (module_update_in),
    .data_valid_out   (data_valid_out),
    .data_out         (data_out)
  );

  // 50 MHz clock
  initial begin
    clk_in = 1'b0;
    forever #10 clk_in = ~clk_in;
  end

  // Cycle counter used to timestamp when each expected output is due.
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One cycle of stimulus; optionally queue the output this sample completes.
  task automatic applyStimulus(input logic valid, input int data, input bit push, input int exp_value);
    @(negedge clk_in);
    adc_data_valid_in = valid;
    adc_data_in       = W_ADC_DATA'(data);
    module_update_in  = 1'b0;
    update_en_in      = 1'b0;
    if (push) sb_q.push_back('{exp_value, cyc + 1});
  endtask

  task automatic sample(input int data);
    applyStimulus(1'b1, data, 1'b0, 0);
  endtask

  task automatic sampleExp(input int data, input int exp_value);
    applyStimulus(1'b1, data, 1'b1, exp_value);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 0);
  endtask

  task automatic commitParams(input int cd, input int osm, input logic en,
                              input logic valid, input int data);
    @(negedge clk_in);
    cycle_delay_in    = W_OSF_CD'(cd);
    osm_in            = W_OSF_OSM'(osm);
    update_en_in      = en;
    module_update_in  = 1'b1;
    adc_data_valid_in = valid;
    adc_data_in       = W_ADC_DATA'(data);
  endtask

  task automatic setActivate(input logic v);
    @(negedge clk_in);
    activate_in       = v;
    adc_data_valid_in = 1'b0;
    module_update_in  = 1'b0;
    update_en_in      = 1'b0;
  endtask

  // Scoreboard monitor: every strobe must match the head of the queue and
  // arrive on its due cycle; a head whose due cycle passes is reported missing.
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (data_valid_out === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_strobe: got data_out=%0d at cycle %0d, expected no strobe",
                   data_out, cyc);
        end else begin
          head = sb_q.pop_front();
          checkOutput("data_out", int'(data_out), head.value);
          checkOutput("strobe_cycle", cyc, head.due);
        end
      end else if (data_valid_out !== 1'b0) begin
        checks++;
        errors++;
        $display("[TB] FAIL data_valid_out_known: got %b, expected 0 or 1", data_valid_out);
      end
      if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        head = sb_q.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL missing_strobe: got none by cycle %0d, expected %0d at cycle %0d",
                 cyc, head.value, head.due);
      end
    end
  end

  initial begin
    checks            = 0;
    errors            = 0;
    cyc               = 0;
    mon_en            = 1'b0;
    reset_n_in        = 1'b0;
    adc_data_valid_in = 1'b0;
    adc_data_in       = '0;
    activate_in       = 1'b1;
    cycle_delay_in    = '0;
    osm_in            = '0;
    update_en_in      = 1'b0;
    module_update_in  = 1'b0;

    // Pass-through vectors (osm=0): each sample comes straight back.
    vecs[0] = '{18'sd131071,  18'sd131071};
    vecs[1] = '{-18'sd131072, -18'sd131072};
    vecs[2] = '{18'sd0,       18'sd0};
    vecs[3] = '{-18'sd1,      -18'sd1};
    vecs[4] = '{18'sd1,       18'sd1};
    vecs[5] = '{18'sd12345,   18'sd12345};

    // Reset held two cycles with the channel active and samples arriving.
    $display("[TB] reset and idle");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_in);
      adc_data_valid_in = 1'b1;
      adc_data_in       = W_ADC_DATA'(1000 + i);
    end
    @(negedge clk_in);
    checkOutput("reset_data_out", int'(data_out), 0);
    checkOutput("reset_valid", int'(data_valid_out), 0);
    reset_n_in        = 1'b1;
    activate_in       = 1'b0;
    adc_data_valid_in = 1'b0;
    mon_en            = 1'b1;
    for (int i = 0; i < 10; i++) sample(50 * i + 7);
    idle(2);

    $display("[TB] basic average");
    commitParams(0, 2, 1'b1, 1'b0, 0);
    setActivate(1'b1);
    sample(100);
    sample(200);
    sample(300);
    sampleExp(400, 250);
    idle(3);
    checkOutput("data_out_hold", int'(data_out), 250);

    $display("[TB] discard and signed floor");
    commitParams(3, 1, 1'b1, 1'b0, 0);
    sample(7);
    sample(7);
    sample(7);
    sample(-3);
    sampleExp(-4, -4);
    idle(3);

    $display("[TB] commit mid-sum then pass-through table");
    commitParams(0, 3, 1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) sample(10);
    commitParams(0, 0, 1'b1, 1'b1, 999);
    sampleExp(42, 42);
    for (int i = 0; i < 6; i++) sampleExp(int'(vecs[i].sample), int'(vecs[i].expected));
    idle(3);

    $display("[TB] clamp and full-scale block");
    commitParams(0, 63, 1'b1, 1'b0, 0);
    for (int i = 0; i < 1023; i++) sample(-131072);
    sampleExp(-131072, -131072);
    idle(2);
    // Update without enable mid-block: must neither clear nor change osm.
    for (int i = 0; i < 1020; i++) sample(5);
    commitParams(7, 0, 1'b0, 1'b1, 5);
    sample(5);
    sample(5);
    sampleExp(5, 5);
    idle(3);

    $display("[TB] deactivate mid-sum");
    commitParams(0, 2, 1'b1, 1'b0, 0);
    sample(1);
    sample(2);
    sample(3);
    setActivate(1'b0);
    idle(2);
    checkOutput("data_out_after_deactivate", int'(data_out), 5);
    setActivate(1'b1);
    sample(8);
    sample(8);
    sample(8);
    sampleExp(9, 8);
    idle(4);

    checkOutput("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oversample_filter.md
Name: oversample_filter

Overview:
- Per-ADC-channel oversampling averager between the ADC controller and the PID core / host readout.
- Discards a programmable number of samples after activation or a parameter change, then sums 2^osm consecutive valid samples.
- Emits the arithmetic mean as a one-cycle-valid word.
- Host-side parameters arrive as raw wires and are committed only on the global update strobe when this channel's update enable is set.

Parameters:
W_ADC_DATA, 18, width of signed ADC sample and filtered output
W_OSF_CD, 16, width of cycle-delay (discard count) parameter
W_OSF_OSM, 6, width of log2 oversample-ratio parameter
OSM_MAX, 10, largest honoured log2 ratio; accumulator is W_ADC_DATA+OSM_MAX bits

Ports:
clk_in  in  1  system clock (50 MHz domain)
reset_n_in  in  1  synchronous active-low reset
adc_data_valid_in  in  1  one-cycle strobe: adc_data_in holds a new sample
adc_data_in  in  W_ADC_DATA  signed two's-complement ADC sample
activate_in  in  1  channel enable (level)
cycle_delay_in  in  W_OSF_CD  staged discard count
osm_in  in  W_OSF_OSM  staged log2 oversample ratio
update_en_in  in  1  this channel accepts the next module update
module_update_in  in  1  one-cycle global parameter-commit strobe
data_valid_out  out  1  one-cycle strobe: data_out updated
data_out  out  W_ADC_DATA  signed averaged sample, held between strobes

Behaviour:
- Reset (reset_n_in=0 at a clk_in edge):
  - acc, sample count, delay count, committed cd/osm, data_out, data_valid_out all become 0; state IDLE.
- Parameter commit:
  - On a cycle with module_update_in & update_en_in: cd_r<=cycle_delay_in; osm_r<=min(osm_in,OSM_MAX).
  - acc and sample count clear. If active, state goes DELAY (cd_in≠0) or SUM (cd_in=0).
  - A sample arriving the same cycle is dropped.
  - module_update_in without update_en_in has no effect.
- States:
  - IDLE: activate_in=0. Samples ignored.
    - Rising activate_in -> DELAY (cd_r≠0, delay count=0) or SUM (cd_r=0).
  - DELAY: each valid sample increments delay count and is discarded.
    - On the sample that makes count==cd_r -> SUM.
  - SUM: acc <= acc + sign-extended sample; count++.
    - On sample number 2^osm_r, the next edge sets data_out <= (acc+sample)>>>osm_r, truncated to W_ADC_DATA, with data_valid_out=1.
    - acc and count clear in the same edge; stay in SUM.
- activate_in falling in any state: next edge -> IDLE.
  - acc and counts clear; no output is emitted for the partial sum.
  - data_out holds its value.
- Latency:
  - data_valid_out asserts exactly one cycle after the final contributing adc_data_valid_in.
  - osm_r=0 gives a pass-through with 1-cycle latency, one output per sample.
- Arithmetic:
  - Shift is arithmetic (floor toward −inf); no rounding.
  - acc cannot overflow because 2^OSM_MAX full-scale samples fit by construction.
- data_valid_out is 0 on every cycle not listed above. It never asserts in IDLE or DELAY.
- Back-to-back valid samples on every cycle are supported with no stall; there is no backpressure.
- Priority within one cycle: reset > commit > deactivate > sample processing.

Decomposition:
- Shared package osf_pkg holds:
  - state enum (IDLE, DELAY, SUM);
  - OSM_MAX default;
  - the accumulator-width function W_ADC_DATA+OSM_MAX.
- No sub-module: counter, accumulator and FSM form one block.
- The N_ADC instances are generated by the parent.

Test Plan:
- Reset/idle: assert reset_n_in=0 for 2 cycles with valids present -> data_out=0, data_valid_out=0; activate_in=0 with 10 samples -> no strobe.
- Basic average: commit cd=0, osm=2; activate; samples 100,200,300,400 -> one strobe, data_out=250, one cycle after the 4th valid.
- Signed floor plus discard: commit cd=3, osm=1; feed 7,7,7 then −3,−4 -> first 3 samples dropped; output −4 (floor of −3.5).
- Commit mid-sum: osm=3, after 5 samples pulse module_update_in with update_en_in=1, osm_in=0, and a valid that same cycle -> that sample dropped, no output for the partial; next sample 42 -> output 42.
- Clamp/width: osm_in=63 -> osm_r=10; feed 1024 samples of −131072 -> output −131072 with no overflow; update with update_en_in=0 -> parameters unchanged.
- Deactivate mid-sum: osm=2; after 3 samples drop activate_in -> no strobe, data_out keeps the prior value; reactivate with cd=0 -> fresh 4-sample average.
